// File: rtl/booth_mult32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult32_pkg
// Description : Shared widths, FSM encoding and 33-bit adder helper for the
//               iterative Booth multiplier.
// Revision    : 1.0
// ============================================================================
package booth_mult32_pkg;

    localparam int c_MULT_WIDTH = 32;
    localparam int c_MULT_ITERS = 32;
    localparam int c_P_WIDTH    = 2 * c_MULT_WIDTH + 2;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // ALU adder widened by one bit so H - M cannot wrap when M = -2^31.
    function automatic logic [32:0] add33(input logic [32:0] a,
                                          input logic [32:0] b,
                                          input logic        cin);
        return a + b + {32'b0, cin};
    endfunction

endpackage : booth_mult32_pkg
`default_nettype wire

// File: rtl/booth_step.sv
`default_nettype none
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth iteration: add/sub M into H, then 1-bit sra.
// Revision    : 1.0
// ============================================================================
module booth_step
    import booth_mult32_pkg::*;
(
    input  logic [65:0] i_p,
    input  logic [32:0] i_m,
    output logic [65:0] o_p_next
);

    logic [32:0] w_h;
    logic [32:0] w_sum;

    assign w_h = i_p[65:33];

    always_comb begin
        w_sum = w_h;
        unique case (i_p[1:0])
            2'b01:   w_sum = add33(w_h, i_m, 1'b0);
            2'b10:   w_sum = add33(w_h, ~i_m, 1'b1);
            default: w_sum = w_h;
        endcase
    end

    assign o_p_next = {w_sum[32], w_sum, i_p[32:1]};

endmodule : booth_step
`default_nettype wire

// File: rtl/booth_mult32.sv
`default_nettype none
// ============================================================================
// Module      : booth_mult32
// Description : Iterative 32x32 signed radix-2 Booth multiplier, low 32 bits
//               of the product plus overflow flag, one-cycle ready pulse.
// Revision    : 1.0
// ============================================================================
module booth_mult32
    import booth_mult32_pkg::*;
#(
    parameter int WIDTH = c_MULT_WIDTH,
    parameter int ITERS = c_MULT_ITERS
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY
);

    state_t      r_state;
    state_t      w_state_next;
    logic [5:0]  r_cnt;
    logic [5:0]  w_cnt_next;
    logic [65:0] r_p;
    logic [65:0] w_p_next;
    logic [65:0] w_p_step;
    logic [32:0] r_m;
    logic [32:0] w_m_next;
    logic        r_rdy;
    logic        w_rdy_next;
    logic [32:0] w_ovf_bits;

    booth_step u_step (
        .i_p      (r_p),
        .i_m      (r_m),
        .o_p_next (w_p_step)
    );

    // A start pulse always wins, in IDLE or mid-operation (abort and reload).
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_p_next     = r_p;
        w_m_next     = r_m;
        w_rdy_next   = 1'b0;
        if (ctrl_MULT) begin
            w_state_next = ST_BUSY;
            w_cnt_next   = 6'd0;
            w_p_next     = {33'b0, data_operandB, 1'b0};
            w_m_next     = {data_operandA[WIDTH-1], data_operandA};
        end else if (r_state == ST_BUSY) begin
            w_p_next   = w_p_step;
            w_cnt_next = r_cnt + 6'd1;
            if (r_cnt == 6'(ITERS - 1)) begin
                w_state_next = ST_IDLE;
                w_rdy_next   = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 6'd0;
            r_p     <= 66'd0;
            r_m     <= 33'd0;
            r_rdy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_p     <= w_p_next;
            r_m     <= w_m_next;
            r_rdy   <= w_rdy_next;
        end
    end

    // Product fits in 32 bits only if H[31:0] is a pure sign extension of L[31].
    assign w_ovf_bits     = r_p[64:32];
    assign data_result    = r_p[32:1];
    assign data_exception = ~((&w_ovf_bits) | ~(|w_ovf_bits));
    assign data_resultRDY = r_rdy;

endmodule : booth_mult32
`default_nettype wire
